// File: rtl/phase_shift_dyn_ctrl.sv
// Dynamic fine-phase-shift controller: single-step inc/dec requests over a PSEN/PSDONE
// handshake, accumulating a wrapped signed step offset and driving base_shift + offset in degrees.
module phase_shift_dyn_ctrl #(
  parameter int unsigned STEPS   = 56,
  parameter int unsigned LATENCY = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psen,
  input  logic               psincdec,
  input  logic signed [31:0] base_shift,
  input  logic               lock_in,
  output logic signed [31:0] shift_out,
  output logic signed [15:0] offset,
  output logic               psdone,
  output logic               busy,
  output logic               ps_err
);

  localparam logic signed [15:0] StepsM1  = 16'(STEPS - 1);
  localparam logic signed [31:0] StepsS   = 32'(STEPS);
  localparam logic        [7:0]  CntLoad  = 8'(LATENCY - 2);

  typedef enum logic [1:0] {StIdle, StApply, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic        [7:0]  cnt_q, cnt_d;
  logic signed [15:0] offset_q, offset_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               psdone_q, psdone_d;
  logic               ps_err_q, ps_err_d;
  logic signed [31:0] shift_q, shift_d;
  logic signed [31:0] off_ext, prod, quot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    psdone_d = 1'b0;
    ps_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psen) begin
          dir_d   = psincdec;
          busy_d  = 1'b1;
          state_d = StApply;
        end
      end
      StApply: begin
        ps_err_d = psen;
        if (dir_q) begin
          offset_d = (offset_q == StepsM1) ? 16'sd0 : offset_q + 16'sd1;
        end else begin
          offset_d = (offset_q == -StepsM1) ? 16'sd0 : offset_q - 16'sd1;
        end
        cnt_d   = CntLoad;
        state_d = StWait;
      end
      StWait: begin
        ps_err_d = psen;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (lock_in == 1'b1) begin
          // x on lock_in fails this test and keeps us waiting
          state_d  = StDone;
          psdone_d = 1'b1;
          busy_d   = 1'b0;
        end
      end
      StDone: begin
        ps_err_d = psen;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Product in 32-bit signed; '/' on signed operands truncates toward zero
  always_comb begin
    off_ext = {{16{offset_q[15]}}, offset_q};
    prod    = off_ext * 32'sd360;
    quot    = prod / StepsS;
    shift_d = base_shift + quot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      offset_q <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      psdone_q <= 1'b0;
      ps_err_q <= 1'b0;
      shift_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      psdone_q <= psdone_d;
      ps_err_q <= ps_err_d;
      shift_q  <= shift_d;
    end
  end

  assign shift_out = shift_q;
  assign offset    = offset_q;
  assign psdone    = psdone_q;
  assign busy      = busy_q;
  assign ps_err    = ps_err_q;

endmodule

// File: tb/tb_phase_shift_dyn_ctrl.sv
// Directed bench for phase_shift_dyn_ctrl with hand-computed expectations (STEPS=56, LATENCY=12).
module tb_phase_shift_dyn_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               psen;
  logic               psincdec;
  logic signed [31:0] base_shift;
  logic               lock_in;
  logic signed [31:0] shift_out;
  logic signed [15:0] offset;
  logic               psdone;
  logic               busy;
  logic               ps_err;

  int n_cmp = 0;
  int n_err = 0;

  phase_shift_dyn_ctrl #(
    .STEPS  (56),
    .LATENCY(12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .psen      (psen),
    .psincdec  (psincdec),
    .base_shift(base_shift),
    .lock_in   (lock_in),
    .shift_out (shift_out),
    .offset    (offset),
    .psdone    (psdone),
    .busy      (busy),
    .ps_err    (ps_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns just after the edge that samples psen (E0 + 1)
  task automatic send_req(input logic dir);
    @(negedge clk);
    psen     = 1'b1;
    psincdec = dir;
    @(posedge clk);
    #1;
    psen     = 1'b0;
    psincdec = 1'b0;
  endtask

  // Edges counted from E0 until psdone is seen; -1 on timeout
  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (psdone) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic step(input logic dir, output int edges);
    send_req(dir);
    wait_done(edges);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    int bad;
    int cnt;
    rst        = 1'b1;
    psen       = 1'b0;
    psincdec   = 1'b0;
    base_shift = 32'sd10;
    lock_in    = 1'b1;

    // Reset / static
    repeat (2) @(negedge clk);
    check("rst_shift", shift_out, 0);
    check("rst_offset", offset, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("static_shift", shift_out, 10);
    check("static_psdone", {31'd0, psdone}, 0);
    check("static_ps_err", {31'd0, ps_err}, 0);
    base_shift = 32'sd0;
    @(posedge clk);
    #1;

    // Single increment
    send_req(1'b1);
    check("single_busy", {31'd0, busy}, 1);
    wait_done(e);
    check("single_latency", e, 12);
    check("single_busy_done", {31'd0, busy}, 0);
    check("single_offset", offset, 1);
    @(posedge clk);
    #1;
    check("single_psdone_width", {31'd0, psdone}, 0);
    check("single_shift", shift_out, 6);

    // Wrap: 54 more increments reach 55
    bad = 0;
    for (int i = 0; i < 54; i++) begin
      step(1'b1, e);
      if (e != 12) bad++;
    end
    check("wrap_latencies", bad, 0);
    check("wrap_offset55", offset, 55);
    check("wrap_shift55", shift_out, 353);
    step(1'b1, e);
    check("wrap_offset56", offset, 0);
    check("wrap_shift56", shift_out, 0);
    step(1'b0, e);
    check("dec_offset", offset, -1);
    check("dec_shift", shift_out, -6);

    // Lock gating: lock low for 20 cycles after E0
    lock_in = 1'b0;
    send_req(1'b1);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (psdone) cnt++;
    end
    check("lock_early_done", cnt, 0);
    lock_in = 1'b1;
    wait_done(e);
    check("lock_done_delay", e, 1);
    check("lock_offset", offset, 0);
    @(posedge clk);
    #1;

    // Busy collision: second psen sampled 3 edges after the first
    send_req(1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    psen     = 1'b1;
    psincdec = 1'b1;
    @(posedge clk);
    #1;
    psen     = 1'b0;
    psincdec = 1'b0;
    check("coll_err_pulse", {31'd0, ps_err}, 1);
    @(posedge clk);
    #1;
    check("coll_err_width", {31'd0, ps_err}, 0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (psdone) cnt++;
    end
    check("coll_done_count", cnt, 1);
    check("coll_offset", offset, -1);

    // Reset mid-WAIT
    base_shift = 32'sd20;
    send_req(1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_offset", offset, 0);
    check("mid_rst_shift", shift_out, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_psdone", {31'd0, psdone}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (psdone) cnt++;
    end
    check("mid_rst_no_done", cnt, 0);
    check("mid_rst_base", shift_out, 20);
    step(1'b1, e);
    check("post_rst_latency", e, 12);
    check("post_rst_offset", offset, 1);
    check("post_rst_shift", shift_out, 26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
